emulador_teclado: RTL and testbench

EMULADOR_TECLADO -- requirements
Module: emulador_teclado

---
 rtl/emulador_teclado.sv | 126 ++++++++++++
 tb/tb_emulador_teclado.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/emulador_teclado.sv
// Keypad emulator: presses one key at a time on an active-low 4x4 row/column matrix,
// with contact bounce at the start of each press followed by a stable hold and a release gap.
module emulador_teclado #(
  parameter int BOUNCE_CYCLES = 8,
  parameter int HOLD_CYCLES   = 200,
  parameter int GAP_CYCLES    = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_value,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] lin_matriz,
  output logic [3:0] col_matriz,
  output logic       key_done,
  output logic       key_error
);

  typedef enum logic [1:0] {IDLE, BOUNCE, HOLD, GAP} state_t;

  localparam logic [15:0] BOUNCE_LOAD = (BOUNCE_CYCLES > 0) ? 16'(BOUNCE_CYCLES - 1) : 16'd0;
  localparam logic [15:0] HOLD_LOAD   = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD    = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  state_t      state;
  logic [15:0] cnt;
  logic        contact_closed;
  logic [3:0]  row_lat;
  logic [3:0]  col_lat;

  // Returns {row, col}; codes C-F are never latched, so they map to the open pattern.
  function automatic logic [7:0] map_key(input logic [3:0] code);
    case (code)
      4'h1:    map_key = {4'b0111, 4'b0111};
      4'h2:    map_key = {4'b0111, 4'b1011};
      4'h3:    map_key = {4'b0111, 4'b1101};
      4'h4:    map_key = {4'b1011, 4'b0111};
      4'h5:    map_key = {4'b1011, 4'b1011};
      4'h6:    map_key = {4'b1011, 4'b1101};
      4'h7:    map_key = {4'b1101, 4'b0111};
      4'h8:    map_key = {4'b1101, 4'b1011};
      4'h9:    map_key = {4'b1101, 4'b1101};
      4'hA:    map_key = {4'b1110, 4'b0111};
      4'h0:    map_key = {4'b1110, 4'b1011};
      4'hB:    map_key = {4'b1110, 4'b1101};
      default: map_key = {4'b1111, 4'b1111};
    endcase
  endfunction

  // key_ready drops for the key_done cycle and returns one cycle later, so a requester
  // holding key_valid is accepted on the first cycle key_ready is seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 16'd0;
      contact_closed <= 1'b0;
      row_lat        <= 4'b1111;
      col_lat        <= 4'b1111;
      key_ready      <= 1'b1;
      key_done       <= 1'b0;
      key_error      <= 1'b0;
    end else begin
      key_done  <= 1'b0;
      key_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!key_ready) begin
            key_ready <= 1'b1;
          end else if (key_valid) begin
            if (key_value <= 4'hB) begin
              {row_lat, col_lat} <= map_key(key_value);
              key_ready          <= 1'b0;
              contact_closed     <= 1'b1;
              if (BOUNCE_CYCLES == 0) begin
                state <= HOLD;
                cnt   <= HOLD_LOAD;
              end else begin
                state <= BOUNCE;
                cnt   <= BOUNCE_LOAD;
              end
            end else begin
              key_error <= 1'b1;
            end
          end
        end
        BOUNCE: begin
          if (cnt == 16'd0) begin
            state          <= HOLD;
            cnt            <= HOLD_LOAD;
            contact_closed <= 1'b1;
          end else begin
            cnt            <= cnt - 16'd1;
            contact_closed <= ~contact_closed;
          end
        end
        HOLD: begin
          if (cnt == 16'd0) begin
            contact_closed <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state    <= IDLE;
              key_done <= 1'b1;
            end else begin
              state <= GAP;
              cnt   <= GAP_LOAD;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        GAP: begin
          if (cnt == 16'd0) begin
            state    <= IDLE;
            key_done <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Any scan pattern other than exactly the latched row (including none or several rows) reads as open.
  assign col_matriz = (contact_closed && (lin_matriz == row_lat)) ? col_lat : 4'b1111;

endmodule

// File: tb/tb_emulador_teclado.sv
// Directed bench for emulador_teclado with default timing (8 bounce, 200 hold, 100 gap cycles).
module tb_emulador_teclado;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_value = 4'h0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic [3:0] lin_matriz = 4'b1111;
  logic [3:0] col_matriz;
  logic       key_done;
  logic       key_error;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [3:0] rot [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  emulador_teclado dut (
    .clk        (clk),
    .rst        (rst),
    .key_value  (key_value),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .lin_matriz (lin_matriz),
    .col_matriz (col_matriz),
    .key_done   (key_done),
    .key_error  (key_error)
  );

  always #5 clk = ~clk;

  // Expected contact state k cycles after the handshake edge.
  function automatic logic contact_at(input int k);
    if (k < 8) return (k % 2) == 0;
    else if (k < 208) return 1'b1;
    else return 1'b0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lin_matriz = rot[i];
      key_valid = 1'b1;
      key_value = 4'h5;
      #1;
      total_cnt++;
      if (col_matriz !== 4'b1111 || key_done !== 1'b0 || key_error !== 1'b0)
        $display("[TB] FAIL reset_outputs col=%b done=%b err=%b, want col=1111 done=0 err=0",
                 col_matriz, key_done, key_error);
      else pass_cnt++;
    end
    key_valid = 1'b0;
    lin_matriz = 4'b1111;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (key_ready !== 1'b1 || col_matriz !== 4'b1111)
      $display("[TB] FAIL reset_release ready=%b col=%b, want ready=1 col=1111", key_ready, col_matriz);
    else pass_cnt++;
  endtask

  task automatic test_press_5();
    logic [3:0] exp_col;
    lin_matriz = 4'b1011;
    key_value = 4'h5;
    key_valid = 1'b1;
    total_cnt++;
    if (key_ready !== 1'b1) $display("[TB] FAIL press5_ready got=%b want=1", key_ready);
    else pass_cnt++;
    for (int k = 0; k <= 309; k++) begin
      @(negedge clk);
      key_valid = 1'b0;
      #1;
      exp_col = contact_at(k) ? 4'b1011 : 4'b1111;
      total_cnt++;
      if (col_matriz !== exp_col)
        $display("[TB] FAIL press5_col k=%0d got=%b want=%b", k, col_matriz, exp_col);
      else pass_cnt++;
      total_cnt++;
      if (key_done !== (k == 308))
        $display("[TB] FAIL press5_done k=%0d got=%b want=%b", k, key_done, (k == 308));
      else pass_cnt++;
      total_cnt++;
      if (key_ready !== (k == 309))
        $display("[TB] FAIL press5_ready k=%0d got=%b want=%b", k, key_ready, (k == 309));
      else pass_cnt++;
    end
    lin_matriz = 4'b1111;
  endtask

  task automatic test_hash_scan();
    logic [3:0] exp_col;
    lin_matriz = 4'b1111;
    key_value = 4'hB;
    key_valid = 1'b1;
    for (int k = 0; k <= 309; k++) begin
      @(negedge clk);
      key_valid = 1'b0;
      if (k == 10) key_value = 4'h1;
      if (k == 30) key_value = 4'h7;
      lin_matriz = (k >= 8 && k < 40) ? rot[k % 4] : 4'b1111;
      #1;
      exp_col = (contact_at(k) && lin_matriz == 4'b1110) ? 4'b1101 : 4'b1111;
      if (k >= 8 && k < 40) begin
        total_cnt++;
        if (col_matriz !== exp_col)
          $display("[TB] FAIL hash_scan k=%0d lin=%b got=%b want=%b", k, lin_matriz, col_matriz, exp_col);
        else pass_cnt++;
      end
      if (k == 308) begin
        total_cnt++;
        if (key_done !== 1'b1) $display("[TB] FAIL hash_done got=%b want=1", key_done);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_invalid();
    key_value = 4'hD;
    key_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      key_valid = 1'b0;
      lin_matriz = rot[k % 4];
      #1;
      total_cnt++;
      if (key_error !== (k == 0))
        $display("[TB] FAIL invalid_err k=%0d got=%b want=%b", k, key_error, (k == 0));
      else pass_cnt++;
      total_cnt++;
      if (col_matriz !== 4'b1111 || key_ready !== 1'b1 || key_done !== 1'b0)
        $display("[TB] FAIL invalid_state k=%0d col=%b ready=%b done=%b, want col=1111 ready=1 done=0",
                 k, col_matriz, key_ready, key_done);
      else pass_cnt++;
    end
    lin_matriz = 4'b1111;
  endtask

  task automatic test_reset_mid();
    lin_matriz = 4'b1110;
    key_value = 4'h0;
    key_valid = 1'b1;
    for (int k = 0; k <= 58; k++) begin
      @(negedge clk);
      key_valid = 1'b0;
    end
    #1;
    total_cnt++;
    if (col_matriz !== 4'b1011) $display("[TB] FAIL midrst_before got=%b want=1011", col_matriz);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if (col_matriz !== 4'b1111 || key_done !== 1'b0)
      $display("[TB] FAIL midrst_release col=%b done=%b, want col=1111 done=0", col_matriz, key_done);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (key_ready !== 1'b1) $display("[TB] FAIL midrst_ready got=%b want=1", key_ready);
    else pass_cnt++;
    for (int k = 0; k < 320; k++) begin
      @(negedge clk);
      lin_matriz = rot[k % 4];
      #1;
      total_cnt++;
      if (key_done !== 1'b0 || col_matriz !== 4'b1111)
        $display("[TB] FAIL midrst_quiet k=%0d done=%b col=%b, want done=0 col=1111", k, key_done, col_matriz);
      else pass_cnt++;
    end
    lin_matriz = 4'b1111;
  endtask

  task automatic test_back_to_back();
    logic [3:0] keys [4] = '{4'h1, 4'h2, 4'h3, 4'hB};
    logic [3:0] rows [4] = '{4'b0111, 4'b0111, 4'b0111, 4'b1110};
    logic [3:0] cols [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1101};
    logic [3:0] exp_col;
    int done_pulses = 0;
    key_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      key_value = keys[i];
      total_cnt++;
      if (key_ready !== 1'b1) $display("[TB] FAIL b2b_ready key=%0d got=%b want=1", i, key_ready);
      else pass_cnt++;
      for (int k = 0; k <= 308; k++) begin
        @(negedge clk);
        lin_matriz = rot[k % 4];
        #1;
        exp_col = (contact_at(k) && lin_matriz == rows[i]) ? cols[i] : 4'b1111;
        total_cnt++;
        if (col_matriz !== exp_col)
          $display("[TB] FAIL b2b_col key=%0d k=%0d lin=%b got=%b want=%b", i, k, lin_matriz, col_matriz, exp_col);
        else pass_cnt++;
        total_cnt++;
        if (key_ready !== 1'b0)
          $display("[TB] FAIL b2b_busy key=%0d k=%0d ready=%b want=0", i, k, key_ready);
        else pass_cnt++;
        if (key_done === 1'b1) done_pulses++;
      end
      @(negedge clk);
      if (i == 3) key_valid = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (key_done === 1'b1) done_pulses++;
    end
    total_cnt++;
    if (done_pulses != 4) $display("[TB] FAIL b2b_done_count got=%0d want=4", done_pulses);
    else pass_cnt++;
    total_cnt++;
    if (key_ready !== 1'b1) $display("[TB] FAIL b2b_final_ready got=%b want=1", key_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_press_5();
    test_hash_scan();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
